pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

- Parametrised, pipelined barrel shifter: the next-generation shift unit for the processor datapath.
- Supports four modes (logical left, arithmetic right, logical right, rotate right) on a WIDTH-bit operand.
- Built as log2(WIDTH) registered stages, with a valid/ready handshake on both sides.
- Sits between the operand-forwarding muxes and the writeback mux; it replaces the single-cycle combinational shifter in the execute stage when running at higher clock rates.

## Interface

Parameters:
- WIDTH, 16, operand width; must be a power of two and at least 4.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports (SHW = log2(WIDTH)):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all pipeline state immediately.
- In_Valid  input  1  the input operation is valid this cycle.
- In_Ready  output  1  the block accepts the operation this cycle.
- Shift_In  input  WIDTH  operand.
- Shift_Val  input  SHW  shift amount, 0..WIDTH-1.
- Mode  input  2  operation select: 00 SLL, 01 SRA, 10 ROR, 11 SRL.
- In_Tag  input  TAG_W  opaque tag, returned unchanged with the result.
- Out_Valid  output  1  the result is valid.
- Out_Ready  input  1  the consumer accepts the result.
- Shift_Out  output  WIDTH  result.
- Out_Tag  output  TAG_W  tag of the result.
- Out_Zero  output  1  high when Shift_Out is all zeros; qualified by Out_Valid.

## Operation

- The pipeline has SHW stages. Stage k (k = 0..SHW-1) conditionally shifts by 2^k, controlled by bit k of Shift_Val.
- Each stage carries: a valid bit, the data, the remaining shift-amount bits, Mode, and the tag.
- Mode semantics per stage when bit k = 1:
  - SLL: shift left, zero fill.
  - SRA: shift right, fill with the original operand MSB. The sign is captured at stage 0 and carried in the pipe.
  - SRL: shift right, zero fill.
  - ROR: rotate right.
- When bit k = 0, the stage passes its data through unchanged.
- Shift_Val = 0 returns Shift_In unchanged in every mode.
- Global advance signal: adv = ~Out_Valid | Out_Ready. In_Ready = adv.
  - When adv = 1, every stage register loads from the previous stage. Stage 0 loads In_Valid and the input fields.
  - When adv = 0, all stages hold their contents.
- Bubbles (valid = 0) advance like data and are not collapsed. Throughput is one operation per cycle while Out_Ready stays high.
- An input transfer occurs when In_Valid & In_Ready. An output transfer occurs when Out_Valid & Out_Ready.
- Out_Zero is computed combinationally from the final stage data.
- Data and tag registers of invalid stages are don't-care but must not produce X on the outputs after reset.

## Timing

- Reset values:
  - All stage valid bits are 0, so Out_Valid = 0.
  - Shift_Out = 0, Out_Tag = 0, Out_Zero = 1.
  - In_Ready = 1.
- Latency: an operation accepted at edge N appears with Out_Valid = 1 after edge N+SHW-1. For WIDTH = 16 it is visible in the cycle following edge N+3, i.e. 4 cycles after acceptance.
- Backpressure: if Out_Valid = 1 and Out_Ready = 0, In_Ready drops combinationally in the same cycle and the whole pipe freezes. Shift_Out, Out_Tag and Out_Valid must stay stable until Out_Ready rises.
- Simultaneous input and output transfer in one cycle is legal and is the steady-state case.
- Reset asserted mid-operation: all in-flight operations are discarded, with no partial outputs. The first acceptance after reset deassertion is at the first rising edge with rst low.
- In_Valid does not depend on In_Ready. The producer must hold its inputs stable while In_Valid = 1 and In_Ready = 0.

## Configuration

- Macro SHIFTER_ROR_EN.
- Defined: Mode 10 performs rotate right as above.
- Undefined:
  - The rotate datapath is not synthesised.
  - Mode 10 returns Shift_In unchanged, irrespective of Shift_Val.
  - All other modes and the timing are identical.

## Test plan

All scenarios use WIDTH = 16.

- Reset: assert rst asynchronously mid-cycle → Out_Valid = 0, Out_Zero = 1 and In_Ready = 1 immediately. An op in flight (SLL 0x0001 by 1) never emerges.
- Single ops, Out_Ready = 1 → results 4 cycles after acceptance:
  - SLL 0x0001 by 15 → 0x8000.
  - SRA 0x8000 by 4 → 0xF800.
  - SRL 0x8000 by 4 → 0x0800.
  - SRA 0x7FF0 by 4 → 0x07FF.
- ROR 0x1234 by 4 → 0x4123, and ROR 0x0001 by 1 → 0x8000 with SHIFTER_ROR_EN defined. Without the macro, both return their input unchanged.
- Streaming: 16 back-to-back ops with tags 0..15 → outputs in order, tags 0..15 on consecutive cycles, no drops.
- Backpressure: hold Out_Ready = 0 for 5 cycles with the pipe full → In_Ready = 0 and Shift_Out and Out_Tag stable throughout. On release, all results drain in order, one per cycle.
- Zero flag: SLL 0x00F0 by 12 → Shift_Out = 0x0000 and Out_Zero = 1. SRA 0xFFFF by 15 → 0xFFFF and Out_Zero = 0.

Source files
------------

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SHW = log2(WIDTH) registered stages, where stage k
// conditionally shifts by 2^k under bit k of the shift amount. A single global
// advance signal moves or freezes the whole pipe (valid/ready on both sides).
// Optional feature macro: SHIFTER_ROR_EN enables the rotate-right datapath for
// Mode 10; without it Mode 10 passes the operand through unchanged.
module pipelined_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [WIDTH-1:0]           Shift_In,
    input  logic [$clog2(WIDTH)-1:0]   Shift_Val,
    input  logic [1:0]                 Mode,
    input  logic [TAG_W-1:0]           In_Tag,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [WIDTH-1:0]           Shift_Out,
    output logic [TAG_W-1:0]           Out_Tag,
    output logic                       Out_Zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

    // One stage of the barrel: shift by 2^k when en is set, else pass through.
    // SRA fills with the operand sign captured on entry, not the current MSB,
    // since after an SLL-free pipe the MSB already equals it but keeping the
    // captured bit makes the intent explicit and independent of stage order.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic             en,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        int               sh;
        sh   = 1 << k;
        fill = ~({WIDTH{1'b1}} >> sh);
        r    = d;
        if (en) begin
            case (mode)
                MODE_SLL: r = d << sh;
                MODE_SRA: r = (d >> sh) | (sign ? fill : '0);
                MODE_SRL: r = d >> sh;
`ifdef SHIFTER_ROR_EN
                MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
`endif
                default:  r = d;
            endcase
        end
        return r;
    endfunction

    // Per-stage pipeline registers (index k = output of stage k)
    logic [SHW-1:0]                 vld_q,  vld_d;
    logic [SHW-1:0][WIDTH-1:0]      data_q, data_d;
    logic [SHW-1:0][SHW-1:0]        amt_q,  amt_d;
    logic [SHW-1:0][1:0]            mode_q, mode_d;
    logic [SHW-1:0]                 sign_q, sign_d;
    logic [SHW-1:0][TAG_W-1:0]      tag_q,  tag_d;

    logic                           adv;

    // Stage-0 inputs are masked with In_Valid so bubbles carry zeros, which
    // keeps X off the outputs even if the producer leaves idle inputs floating.
    logic [WIDTH-1:0]               in_data;
    logic [SHW-1:0]                 in_amt;
    logic [1:0]                     in_mode;
    logic                           in_sign;
    logic [TAG_W-1:0]               in_tag;

    assign in_data = In_Valid ? Shift_In  : '0;
    assign in_amt  = In_Valid ? Shift_Val : '0;
    assign in_mode = In_Valid ? Mode      : MODE_SLL;
    assign in_sign = In_Valid & Shift_In[WIDTH-1];
    assign in_tag  = In_Valid ? In_Tag    : '0;

    // The whole pipe advances together unless a valid result is being held.
    assign adv      = ~Out_Valid | Out_Ready;
    assign In_Ready = adv;

    // Next state: hold everything by default, shift every stage on advance.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        amt_d  = amt_q;
        mode_d = mode_q;
        sign_d = sign_q;
        tag_d  = tag_q;
        if (adv) begin
            vld_d[0]  = In_Valid;
            data_d[0] = shift_stage(in_data, 0, in_amt[0], in_mode, in_sign);
            amt_d[0]  = in_amt;
            mode_d[0] = in_mode;
            sign_d[0] = in_sign;
            tag_d[0]  = in_tag;
            for (int k = 1; k < SHW; k++) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = shift_stage(data_q[k-1], k, amt_q[k-1][k],
                                        mode_q[k-1], sign_q[k-1]);
                amt_d[k]  = amt_q[k-1];
                mode_d[k] = mode_q[k-1];
                sign_d[k] = sign_q[k-1];
                tag_d[k]  = tag_q[k-1];
            end
        end
    end

    // Pipeline state; asynchronous reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            amt_q  <= '0;
            mode_q <= '0;
            sign_q <= '0;
            tag_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            amt_q  <= amt_d;
            mode_q <= mode_d;
            sign_q <= sign_d;
            tag_q  <= tag_d;
        end
    end

    assign Out_Valid = vld_q[SHW-1];
    assign Shift_Out = data_q[SHW-1];
    assign Out_Tag   = tag_q[SHW-1];
    assign Out_Zero  = ~|data_q[SHW-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=16): directed and random
// operations against a plain-arithmetic reference model and an in-order
// expectation queue. Honours SHIFTER_ROR_EN for the rotate expectations.
module tb_pipelined_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] Shift_In;
    logic [3:0]  Shift_Val;
    logic [1:0]  Mode;
    logic [3:0]  In_Tag;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Shift_Out;
    logic [3:0]  Out_Tag;
    logic        Out_Zero;

    pipelined_shifter #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Shift_In(Shift_In), .Shift_Val(Shift_Val), .Mode(Mode), .In_Tag(In_Tag),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Shift_Out(Shift_Out), .Out_Tag(Out_Tag), .Out_Zero(Out_Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  t;
        int          c;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc   = 0;
    bit   lat_chk = 1'b0;
    logic popped;

    // Reference: the four shift rules written with ordinary operators.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] s,
                                          input logic [1:0] m);
        logic signed [15:0] sd;
        logic [31:0]        x;
        int                 n;
        sd = d;
        x  = {16'h0, d};
        n  = s;
        case (m)
            2'b00: model = d << n;
            2'b01: model = sd >>> n;
            2'b11: model = d >> n;
            default: begin
`ifdef SHIFTER_ROR_EN
                x = (x >> n) | (x << (16 - n));
                model = x[15:0];
`else
                model = d;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check/record the transfers the next edge performs.
    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] s,
                        input logic [1:0] m, input logic [3:0] t, input logic ordy,
                        input logic [15:0] expd);
        exp_t e;
        @(negedge clk);
        In_Valid = v; Shift_In = d; Shift_Val = s; Mode = m; In_Tag = t;
        Out_Ready = ordy;
        #1;
        cyc++;
        popped = 1'b0;
        if (Out_Valid === 1'b1 && Out_Ready) begin
            chk("unexpected_output", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("data", Shift_Out, e.d);
                chk("tag",  Out_Tag,   e.t);
                chk("zero", Out_Zero,  (e.d == 16'h0));
                if (lat_chk) chk("latency", cyc - e.c, 4);
                popped = 1'b1;
            end
        end
        if (In_Valid && In_Ready === 1'b1) begin
            e.d = expd; e.t = t; e.c = cyc;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 4'h0, 2'b00, 4'h0, 1'b1, 16'h0);
    endtask

    task automatic run_single(input logic [15:0] d, input logic [3:0] s,
                              input logic [1:0] m, input logic [3:0] t,
                              input logic [15:0] expd);
        step(1'b1, d, s, m, t, 1'b1, expd);
        for (int i = 0; i < 8 && q.size() > 0; i++) idle();
        chk("single_done", q.size(), 0);
    endtask

    logic [15:0] rd;
    logic [3:0]  rs;
    logic [1:0]  rm;
    logic [3:0]  rt;

    initial begin
        rst = 1'b1; In_Valid = 1'b0; Shift_In = '0; Shift_Val = '0; Mode = '0;
        In_Tag = '0; Out_Ready = 1'b1;
        #12;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_shift_out", Shift_Out, 0);
        chk("rst_out_tag",   Out_Tag,   0);
        chk("rst_out_zero",  Out_Zero,  1);
        chk("rst_in_ready",  In_Ready,  1);
        @(negedge clk);
        rst = 1'b0;

        // Mid-operation reset: op reaches the output, is held, then discarded.
        step(1'b1, 16'h0001, 4'd1, 2'b00, 4'd5, 1'b1, 16'h0002);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 4'h0, 2'b00, 4'h0, 1'b0, 16'h0);
        chk("pre_rst_valid", Out_Valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", Out_Valid, 0);
        chk("async_rst_zero",  Out_Zero,  1);
        chk("async_rst_ready", In_Ready,  1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("flush_no_out", Out_Valid, 0);
        end

        // Directed single operations with fixed expectations and latency.
        lat_chk = 1'b1;
        run_single(16'h0001, 4'd15, 2'b00, 4'd1, 16'h8000);
        run_single(16'h8000, 4'd4,  2'b01, 4'd2, 16'hF800);
        run_single(16'h8000, 4'd4,  2'b11, 4'd3, 16'h0800);
        run_single(16'h7FF0, 4'd4,  2'b01, 4'd4, 16'h07FF);
`ifdef SHIFTER_ROR_EN
        run_single(16'h1234, 4'd4,  2'b10, 4'd5, 16'h4123);
        run_single(16'h0001, 4'd1,  2'b10, 4'd6, 16'h8000);
`else
        run_single(16'h1234, 4'd4,  2'b10, 4'd5, 16'h1234);
        run_single(16'h0001, 4'd1,  2'b10, 4'd6, 16'h0001);
`endif
        run_single(16'h00F0, 4'd12, 2'b00, 4'd7, 16'h0000);
        run_single(16'hFFFF, 4'd15, 2'b01, 4'd8, 16'hFFFF);
        run_single(16'hA5C3, 4'd0,  2'b00, 4'd9, 16'hA5C3);
        run_single(16'hA5C3, 4'd0,  2'b01, 4'd10, 16'hA5C3);
        run_single(16'hA5C3, 4'd0,  2'b10, 4'd11, 16'hA5C3);
        run_single(16'hA5C3, 4'd0,  2'b11, 4'd12, 16'hA5C3);

        // Streaming: 16 back-to-back ops, tags 0..15, fixed latency => no gaps.
        for (int i = 0; i < 16; i++) begin
            rd = 16'($urandom); rs = 4'($urandom_range(0, 15)); rm = 2'($urandom_range(0, 3));
            step(1'b1, rd, rs, rm, 4'(i), 1'b1, model(rd, rs, rm));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) idle();
        chk("stream_drained", q.size(), 0);

        // Backpressure: fill the pipe, stall 5 cycles with a pending op, release.
        lat_chk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd = 16'($urandom); rs = 4'($urandom_range(0, 15)); rm = 2'($urandom_range(0, 3));
            step(1'b1, rd, rs, rm, 4'(i + 1), 1'b1, model(rd, rs, rm));
        end
        rd = 16'($urandom); rs = 4'($urandom_range(1, 15)); rm = 2'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rd, rs, rm, 4'd5, 1'b0, model(rd, rs, rm));
            chk("bp_in_ready",  In_Ready,  0);
            chk("bp_out_valid", Out_Valid, 1);
            chk("bp_hold_data", Shift_Out, q[0].d);
            chk("bp_hold_tag",  Out_Tag,   q[0].t);
        end
        step(1'b1, rd, rs, rm, 4'd5, 1'b1, model(rd, rs, rm));
        chk("bp_release_pop", popped, 1);
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            idle();
            chk("bp_drain_gap", popped, 1);
        end
        chk("bp_drained", q.size(), 0);

        // Random traffic with random bubbles and random backpressure.
        for (int i = 0; i < 60; i++) begin
            rd = 16'($urandom); rs = 4'($urandom_range(0, 15)); rm = 2'($urandom_range(0, 3));
            rt = 4'($urandom);
            step(1'($urandom_range(0, 1)), rd, rs, rm, rt, 1'($urandom_range(0, 3) != 0),
                 model(rd, rs, rm));
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        chk("rand_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
